// File: rtl/vector_exec_unit_if.sv
// vector_exec_unit_if: operand/control/result bundle for vector_exec_unit.
// Signals: rdy_in, execute, length, vs1, vs2, vd_old, mask, vm, imm, rs, op, operand_type, result, status, done.
// master drives the request side and reads result/status/done; slave is the execution unit.
interface vector_exec_unit_if #(
   parameter int LEN = 32,
   parameter int VECTOR_SIZE = 8,
   parameter int ENTRY_INDEX_SIZE = 3
);
   logic rdy_in;
   logic execute;
   logic [ENTRY_INDEX_SIZE:0] length;
   logic [VECTOR_SIZE*LEN-1:0] vs1;
   logic [VECTOR_SIZE*LEN-1:0] vs2;
   logic [VECTOR_SIZE*LEN-1:0] vd_old;
   logic [VECTOR_SIZE-1:0] mask;
   logic vm;
   logic [LEN-1:0] imm;
   logic [LEN-1:0] rs;
   logic [2:0] op;
   logic [1:0] operand_type;
   logic [VECTOR_SIZE*LEN-1:0] result;
   logic [1:0] status;
   logic done;
   modport master (
      output rdy_in, execute, length, vs1, vs2, vd_old, mask, vm, imm, rs, op, operand_type,
      input result, status, done
   );
   modport slave (
      input rdy_in, execute, length, vs1, vs2, vd_old, mask, vm, imm, rs, op, operand_type,
      output result, status, done
   );
endinterface

// File: rtl/vector_exec_unit.sv
// vector_exec_unit: multi-cycle vector ALU processing LANE_SIZE elements per enabled cycle.
// Ports: clk (rising edge), rst (asynchronous, active-low), bus (vector_exec_unit_if.slave).
// status 00 IDLE / 01 WORKING / 10 FINISHED; done is high while FINISHED.
// Macro VEC_EXEC_MASK_EN: when defined, vm=0 lets mask bit i suppress the write of element i.
module vector_exec_unit #(
   parameter int LEN = 32,
   parameter int VECTOR_SIZE = 8,
   parameter int ENTRY_INDEX_SIZE = 3,
   parameter int LANE_SIZE = 2
) (
   input logic clk,
   input logic rst,
   vector_exec_unit_if.slave bus
);
   localparam int SH = $clog2(LEN);
   localparam int IW = ENTRY_INDEX_SIZE + 1;
   typedef enum logic [1:0] {IDLE = 2'b00, WORKING = 2'b01, FINISHED = 2'b10} state_t;
   state_t state, state_d;
   logic [IW-1:0] nxt, nxt_d, len_q, len_c;
   logic [VECTOR_SIZE*LEN-1:0] vs1_q, vs2_q, res_q;
   logic [LEN-1:0] imm_q, rs_q;
   logic [2:0] op_q;
   logic [1:0] ot_q;
`ifdef VEC_EXEC_MASK_EN
   logic [VECTOR_SIZE-1:0] mask_q;
   logic vm_q;
`endif
   logic accept, fin;
   logic [LEN-1:0] lane_val [LANE_SIZE];
   logic [ENTRY_INDEX_SIZE-1:0] lane_idx [LANE_SIZE];
   logic [LANE_SIZE-1:0] lane_we;

   function automatic logic [LEN-1:0] alu(input logic [2:0] o, input logic [LEN-1:0] a,
                                          input logic [LEN-1:0] b);
      return o == 3'd0 ? a + b : o == 3'd1 ? a - b : o == 3'd2 ? a & b : o == 3'd3 ? a | b :
             o == 3'd4 ? a ^ b : o == 3'd5 ? a << b[SH-1:0] : o == 3'd6 ? a >> b[SH-1:0] :
             ($signed(a) < $signed(b) ? a : b);
   endfunction

   assign accept = bus.rdy_in && bus.execute && bus.length != '0 && state != WORKING;
   assign len_c = bus.length > IW'(VECTOR_SIZE) ? IW'(VECTOR_SIZE) : bus.length;
   // widened by one bit so nxt+LANE_SIZE cannot wrap before the compare
   assign fin = ({1'b0, nxt} + (IW+1)'(LANE_SIZE)) >= {1'b0, len_q};
   assign bus.result = res_q;
   assign bus.status = state;
   assign bus.done = state == FINISHED;

   always_comb begin
      state_d = accept ? WORKING : state == WORKING ? (fin ? FINISHED : WORKING) : IDLE;
      nxt_d = state == WORKING ? nxt + IW'(LANE_SIZE) : '0;
   end

   // lane j handles element nxt+j; an out-of-range element is never written, so its
   // truncated index is harmless
   always_comb begin
      for (int j = 0; j < LANE_SIZE; j++) begin
         lane_idx[j] = ENTRY_INDEX_SIZE'(int'(nxt) + j);
`ifdef VEC_EXEC_MASK_EN
         lane_we[j] = (int'(nxt) + j) < int'(len_q) && (vm_q || mask_q[lane_idx[j]]);
`else
         lane_we[j] = (int'(nxt) + j) < int'(len_q);
`endif
         lane_val[j] = alu(op_q, vs2_q[lane_idx[j]*LEN +: LEN],
                           ot_q == 2'd1 ? rs_q : ot_q == 2'd2 ? imm_q : vs1_q[lane_idx[j]*LEN +: LEN]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         nxt <= '0;
         len_q <= '0;
         vs1_q <= '0;
         vs2_q <= '0;
         res_q <= '0;
         imm_q <= '0;
         rs_q <= '0;
         op_q <= '0;
         ot_q <= '0;
`ifdef VEC_EXEC_MASK_EN
         mask_q <= '0;
         vm_q <= 1'b0;
`endif
      end else if (bus.rdy_in) begin
         state <= state_d;
         nxt <= nxt_d;
         if (accept) begin
            len_q <= len_c;
            vs1_q <= bus.vs1;
            vs2_q <= bus.vs2;
            res_q <= bus.vd_old;
            imm_q <= bus.imm;
            rs_q <= bus.rs;
            op_q <= bus.op;
            ot_q <= bus.operand_type;
`ifdef VEC_EXEC_MASK_EN
            mask_q <= bus.mask;
            vm_q <= bus.vm;
`endif
         end else if (state == WORKING) begin
            for (int j = 0; j < LANE_SIZE; j++)
               if (lane_we[j]) res_q[lane_idx[j]*LEN +: LEN] <= lane_val[j];
         end
      end
   end
endmodule

// File: tb/tb_vector_exec_unit.sv
// tb_vector_exec_unit: randomized self-checking bench for vector_exec_unit against an element-wise model.
module tb_vector_exec_unit;
   localparam int LEN = 32;
   localparam int VS = 8;
   localparam int EIS = 3;
   localparam int LANE = 2;
   typedef logic [VS*LEN-1:0] vec_t;

   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vector_exec_unit_if #(.LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS)) bus ();
   vector_exec_unit #(.LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS), .LANE_SIZE(LANE))
      dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic vec_t rv();
      vec_t v;
      for (int i = 0; i < VS; i++) v[i*LEN +: LEN] = $urandom;
      return v;
   endfunction

   function automatic int n_of(input int len);
      return len > VS ? VS : len;
   endfunction

   function automatic int cycles_of(input int len);
      return (n_of(len) + LANE - 1) / LANE;
   endfunction

   // element-wise reference: elements below the clamped length get vs2 op B unless masked
   function automatic vec_t model(input logic [2:0] op, input logic [1:0] ot, input int len,
                                  input vec_t a1, input vec_t a2, input vec_t vd,
                                  input logic [VS-1:0] m, input logic vm,
                                  input logic [LEN-1:0] imm, input logic [LEN-1:0] rs);
      vec_t r;
      logic [LEN-1:0] a, b, y;
      bit wr;
      r = vd;
      for (int e = 0; e < n_of(len); e++) begin
         a = a2[e*LEN +: LEN];
         b = ot == 2'd1 ? rs : ot == 2'd2 ? imm : a1[e*LEN +: LEN];
         case (op)
            3'd0: y = a + b;
            3'd1: y = a - b;
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = a << (b % LEN);
            3'd6: y = a >> (b % LEN);
            default: y = ($signed(a) < $signed(b)) ? a : b;
         endcase
`ifdef VEC_EXEC_MASK_EN
         wr = vm || m[e];
`else
         wr = 1'b1;
`endif
         if (wr) r[e*LEN +: LEN] = y;
      end
      return r;
   endfunction

   function automatic vec_t model_bus();
      return model(bus.op, bus.operand_type, int'(bus.length), bus.vs1, bus.vs2, bus.vd_old,
                   bus.mask, bus.vm, bus.imm, bus.rs);
   endfunction

   task automatic scramble();
      bus.vs1 = rv();
      bus.vs2 = rv();
      bus.vd_old = rv();
      bus.rs = $urandom;
      bus.imm = $urandom;
      bus.op = 3'($urandom);
      bus.operand_type = 2'($urandom);
      bus.length = 4'($urandom);
      bus.mask = 8'($urandom);
      bus.vm = 1'($urandom);
   endtask

   // called at a negedge; issues execute for one edge and counts edges after accept until done
   task automatic go(input bit scr, input int exp, output int cyc, output logic [1:0] st1);
      bus.execute = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st1 = bus.status;
      bus.execute = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 50) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         bus.execute = scr && cyc == 1 && exp >= 2;
         if (scr) scramble();
      end
      if (!bus.done) cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.rdy_in = 1'b1;
      bus.execute = 1'b1;
      bus.length = 4'd4;
      bus.vd_old = rv();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.status !== 2'b00) begin failures++; $display("FAIL reset_status got=%b want=00", bus.status); end
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
      checks++;
      if (bus.result !== '0) begin failures++; $display("FAIL reset_result got=%h want=0", bus.result); end
      bus.execute = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add_vv();
      vec_t exp;
      int cyc;
      logic [1:0] st1;
      bus.op = 3'd0;
      bus.operand_type = 2'd0;
      bus.length = 4'd8;
      bus.vm = 1'b1;
      bus.mask = '0;
      bus.vd_old = rv();
      for (int i = 0; i < VS; i++) begin
         bus.vs1[i*LEN +: LEN] = 32'd1;
         bus.vs2[i*LEN +: LEN] = 32'(i);
         exp[i*LEN +: LEN] = 32'(i + 1);
      end
      go(1'b0, 4, cyc, st1);
      checks++;
      if (st1 !== 2'b01) begin failures++; $display("FAIL add_working_status got=%b want=01", st1); end
      checks++;
      if (cyc !== 4) begin failures++; $display("FAIL add_cycles got=%0d want=4", cyc); end
      checks++;
      if (bus.status !== 2'b10) begin failures++; $display("FAIL add_finished_status got=%b want=10", bus.status); end
      checks++;
      if (bus.result !== exp) begin failures++; $display("FAIL add_result got=%h want=%h", bus.result, exp); end
   endtask

   task automatic test_sub_vx();
      vec_t exp;
      int cyc;
      logic [1:0] st1;
      bus.op = 3'd1;
      bus.operand_type = 2'd1;
      bus.rs = 32'd1;
      bus.length = 4'd5;
      bus.vs1 = rv();
      for (int i = 0; i < VS; i++) begin
         bus.vs2[i*LEN +: LEN] = 32'(10 + i);
         bus.vd_old[i*LEN +: LEN] = 32'hAAAAAAAA;
         exp[i*LEN +: LEN] = i < 5 ? 32'(9 + i) : 32'hAAAAAAAA;
      end
      go(1'b0, 3, cyc, st1);
      checks++;
      if (cyc !== 3) begin failures++; $display("FAIL sub_cycles got=%0d want=3", cyc); end
      checks++;
      if (bus.result !== exp) begin failures++; $display("FAIL sub_result got=%h want=%h", bus.result, exp); end
   endtask

   vec_t mask_res;

   task automatic test_mask();
      vec_t exp;
      logic [LEN-1:0] e1;
      int cyc;
      logic [1:0] st1;
      bus.op = 3'd0;
      bus.operand_type = 2'd0;
      bus.length = 4'd8;
      bus.vm = 1'b0;
      bus.mask = 8'b01010101;
      bus.vs1 = rv();
      bus.vs2 = rv();
      bus.vd_old = rv();
      exp = model_bus();
`ifdef VEC_EXEC_MASK_EN
      e1 = bus.vd_old[LEN +: LEN];
`else
      e1 = bus.vs2[LEN +: LEN] + bus.vs1[LEN +: LEN];
`endif
      go(1'b0, 4, cyc, st1);
      checks++;
      if (bus.result !== exp) begin failures++; $display("FAIL mask_result got=%h want=%h", bus.result, exp); end
      checks++;
      if (bus.result[LEN +: LEN] !== e1) begin failures++; $display("FAIL mask_elem1 got=%h want=%h", bus.result[LEN +: LEN], e1); end
      mask_res = exp;
      bus.vm = 1'b1;
   endtask

   task automatic test_len_zero();
      bus.length = 4'd0;
      bus.execute = 1'b1;
      bus.vd_old = rv();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.status !== 2'b00) begin failures++; $display("FAIL len0_status got=%b want=00", bus.status); end
      checks++;
      if (bus.result !== mask_res) begin failures++; $display("FAIL len0_hold got=%h want=%h", bus.result, mask_res); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.status !== 2'b00) begin failures++; $display("FAIL len0_still_idle got=%b want=00", bus.status); end
      bus.execute = 1'b0;
   endtask

   task automatic test_clamp();
      vec_t exp;
      int cyc;
      logic [1:0] st1;
      bus.op = 3'd4;
      bus.operand_type = 2'd2;
      bus.imm = $urandom;
      bus.length = 4'd13;
      bus.vs2 = rv();
      bus.vd_old = rv();
      exp = model_bus();
      go(1'b0, 4, cyc, st1);
      checks++;
      if (cyc !== 4) begin failures++; $display("FAIL clamp_cycles got=%0d want=4", cyc); end
      checks++;
      if (bus.result !== exp) begin failures++; $display("FAIL clamp_result got=%h want=%h", bus.result, exp); end
   endtask

   task automatic test_stall();
      vec_t exp, r1;
      logic [1:0] s1;
      int cyc;
      bus.op = 3'd7;
      bus.operand_type = 2'd0;
      bus.length = 4'd8;
      bus.vs1 = rv();
      bus.vs2 = rv();
      bus.vd_old = rv();
      exp = model_bus();
      bus.execute = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.execute = 1'b0;
      @(posedge clk);
      @(negedge clk);
      r1 = bus.result;
      s1 = bus.status;
      bus.rdy_in = 1'b0;
      bus.execute = 1'b1;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (bus.result !== r1) begin failures++; $display("FAIL stall_result_hold got=%h want=%h", bus.result, r1); end
      checks++;
      if (bus.status !== 2'b01 || s1 !== 2'b01) begin failures++; $display("FAIL stall_status got=%b/%b want=01/01", s1, bus.status); end
      bus.rdy_in = 1'b1;
      bus.execute = 1'b0;
      cyc = 3;
      while (!bus.done && cyc < 50) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 6) begin failures++; $display("FAIL stall_cycles got=%0d want=6", cyc); end
      checks++;
      if (bus.result !== exp) begin failures++; $display("FAIL stall_result got=%h want=%h", bus.result, exp); end
   endtask

   task automatic test_back_to_back();
      vec_t exp;
      int cyc;
      logic [1:0] st1;
      bus.op = 3'd2;
      bus.operand_type = 2'd3;
      bus.length = 4'd3;
      bus.vs1 = rv();
      bus.vs2 = rv();
      bus.vd_old = rv();
      go(1'b0, 2, cyc, st1);
      bus.op = 3'd5;
      bus.operand_type = 2'd1;
      bus.rs = 32'($urandom_range(0, 63));
      bus.length = 4'd7;
      bus.vs2 = rv();
      bus.vd_old = rv();
      exp = model_bus();
      go(1'b0, 4, cyc, st1);
      checks++;
      if (st1 !== 2'b01) begin failures++; $display("FAIL b2b_no_idle got=%b want=01", st1); end
      checks++;
      if (cyc !== 4) begin failures++; $display("FAIL b2b_cycles got=%0d want=4", cyc); end
      checks++;
      if (bus.result !== exp) begin failures++; $display("FAIL b2b_result got=%h want=%h", bus.result, exp); end
   endtask

   task automatic test_reset_mid();
      vec_t exp;
      int cyc;
      logic [1:0] st1;
      bus.op = 3'd3;
      bus.operand_type = 2'd0;
      bus.length = 4'd8;
      bus.vs1 = rv();
      bus.vs2 = rv();
      bus.vd_old = rv();
      bus.execute = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.execute = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.status !== 2'b00 || bus.done !== 1'b0) begin failures++; $display("FAIL rstmid_status got=%b/%b want=00/0", bus.status, bus.done); end
      checks++;
      if (bus.result !== '0) begin failures++; $display("FAIL rstmid_result got=%h want=0", bus.result); end
      @(negedge clk);
      rst = 1'b1;
      bus.op = 3'd6;
      bus.operand_type = 2'd2;
      bus.imm = 32'($urandom_range(0, 40));
      bus.length = 4'd6;
      bus.vs2 = rv();
      bus.vd_old = rv();
      exp = model_bus();
      go(1'b0, 3, cyc, st1);
      checks++;
      if (cyc !== 3) begin failures++; $display("FAIL rstmid_after_cycles got=%0d want=3", cyc); end
      checks++;
      if (bus.result !== exp) begin failures++; $display("FAIL rstmid_after_result got=%h want=%h", bus.result, exp); end
   endtask

   task automatic test_random();
      vec_t exp;
      int cyc, ec;
      logic [1:0] st1;
      for (int k = 0; k < 24; k++) begin
         scramble();
         bus.length = 4'($urandom_range(1, 15));
         exp = model_bus();
         ec = cycles_of(int'(bus.length));
         go(1'b1, ec, cyc, st1);
         checks++;
         if (cyc !== ec) begin failures++; $display("FAIL rand%0d_cycles got=%0d want=%0d", k, cyc, ec); end
         checks++;
         if (bus.result !== exp) begin failures++; $display("FAIL rand%0d_result got=%h want=%h", k, bus.result, exp); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bus.rdy_in = 1'b1;
      bus.execute = 1'b0;
      bus.length = '0;
      bus.vs1 = '0;
      bus.vs2 = '0;
      bus.vd_old = '0;
      bus.mask = '0;
      bus.vm = 1'b1;
      bus.imm = '0;
      bus.rs = '0;
      bus.op = '0;
      bus.operand_type = '0;
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_add_vv();
      test_sub_vx();
      test_mask();
      test_len_zero();
      test_clamp();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 Parameter LEN, default 32: element width in bits.
REQ-002 Parameter VECTOR_SIZE, default 8: maximum elements per vector.
REQ-003 Parameter ENTRY_INDEX_SIZE, default 3: log2(VECTOR_SIZE).
REQ-004 Parameter LANE_SIZE, default 2: elements processed per cycle, 1..VECTOR_SIZE.
REQ-005 One clock and one reset; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 rdy_in  input  1  global enable; low freezes all state.
REQ-009 execute  input  1  request to start an operation.
REQ-010 length  input  ENTRY_INDEX_SIZE+1  active element count.
REQ-011 vs1, vs2, vd_old  input  VECTOR_SIZE*LEN  source operands and prior destination value.
REQ-012 mask  input  VECTOR_SIZE  per-element mask, bit i for element i.
REQ-013 vm  input  1  1 = unmasked, 0 = masked by mask.
REQ-014 imm, rs  input  LEN  immediate and scalar operands.
REQ-015 op  input  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 min (signed).
REQ-016 operand_type  input  2  0 vv (vs1), 1 vx (rs), 2 vi (imm), 3 treated as vv.
REQ-017 result  output  VECTOR_SIZE*LEN  destination vector.
REQ-018 status  output  2  00 IDLE, 01 WORKING, 10 FINISHED.
REQ-019 done  output  1  high exactly while status is FINISHED.

Function
REQ-020 Accept: in IDLE or FINISHED, when rdy_in=1, execute=1 and length>0, latch all inputs, load result with vd_old, set next=0, enter WORKING.
REQ-021 length>VECTOR_SIZE is clamped to VECTOR_SIZE at accept.
REQ-022 execute with length=0 is ignored.
REQ-023 In WORKING, per cycle, lane j computes element e=next+j for j<LANE_SIZE; only e<length is written.
REQ-024 Element result = vs2[e] op B, where B is vs1[e], rs or imm per operand_type; sub is vs2-B.
REQ-025 Shifts use B[log2(LEN)-1:0]; arithmetic wraps modulo 2^LEN.
REQ-026 An element with vm=0 and mask[e]=0 keeps vd_old[e].
REQ-027 Tail elements (e>=length) keep vd_old[e].
REQ-028 next advances by LANE_SIZE each WORKING cycle; when next+LANE_SIZE>=length, go to FINISHED.
REQ-029 WORKING lasts exactly ceil(length/LANE_SIZE) enabled cycles.
REQ-030 execute during WORKING is ignored; latched operands do not change.
REQ-031 FINISHED lasts one enabled cycle: it re-accepts if REQ-020 holds, else it goes to IDLE.
REQ-032 result holds its value from FINISHED until the next accept.
REQ-033 rdy_in=0 holds state, next and result unchanged; the operation resumes when rdy_in returns to 1.
REQ-034 Inputs are sampled only at accept.

Reset
REQ-035 rst=0 immediately forces status=IDLE, done=0, result=0 and next=0, and clears all latched operands, including when reset occurs mid-WORKING.

Configuration
REQ-036 Macro VEC_EXEC_MASK_EN defined: masking per REQ-026.
REQ-037 Macro VEC_EXEC_MASK_EN undefined: mask and vm are ignored, and every element e<length is written.

Verification
REQ-038 Reset asserted -> status=00, done=0, result=0.
REQ-039 LANE_SIZE=2, vv add, length=8, vs1[i]=1, vs2[i]=i -> result[i]=i+1; FINISHED 4 cycles after the accept edge.
REQ-040 vx sub, rs=1, length=5, vs2[i]=10+i, vd_old all 0xAAAAAAAA -> elements 0..4 = 9..13, elements 5..7 = 0xAAAAAAAA; 3 WORKING cycles.
REQ-041 vv add, vm=0, mask=8'b01010101, length=8 -> odd elements = vd_old; with the macro undefined, all elements are written.
REQ-042 rdy_in low for 2 cycles mid-WORKING -> FINISHED 2 cycles later, with a result identical to the unstalled run.
REQ-043 execute held in FINISHED -> direct to WORKING with no IDLE cycle; rst low mid-WORKING -> IDLE, result=0, and the next accept behaves normally.
